// File: rtl/result_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle) driving a
// multiplexed eight-digit active-low seven-segment display with leading-zero blanking.
module result_display #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] value,
    output logic        busy,
    output logic        ready,
    output logic        overflow,
    output logic [31:0] bcd,
    output logic [7:0]  digit_sel,
    output logic [6:0]  segments,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        start_q;
    logic        accept;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_q;
    logic [39:0] scratch_q;
    logic [39:0] scratch_adj;
    logic [39:0] scratch_nxt;
    logic [15:0] refresh_cnt;
    logic [2:0]  digit_idx;
    logic [3:0]  nibble;
    logic [31:0] upper;
    logic [6:0]  seg_nxt;

    // Handshake: load is a one-cycle strobe honoured only outside CONVERT. The value
    // is captured on that edge, CONVERT starts one edge later and lasts 32 cycles,
    // then ready stays high (bcd valid) until the next accepted load or clear.
    assign accept = load && (state != CONVERT) && !start_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_q) state_nxt = CONVERT;
            CONVERT:    if (bit_cnt == 5'd31) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CONVERT);
        ready     = (state == DONE);
        state_dbg = state;
    end

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 10; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        scratch_nxt = {scratch_adj[38:0], shift_q[31]};
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            start_q   <= 1'b0;
            bit_cnt   <= 5'd0;
            shift_q   <= 32'd0;
            scratch_q <= 40'd0;
            bcd       <= 32'd0;
            overflow  <= 1'b0;
        end else begin
            start_q <= accept;
            if (accept) begin
                shift_q   <= value;
                scratch_q <= 40'd0;
                bit_cnt   <= 5'd0;
            end else if (state == CONVERT) begin
                {scratch_q, shift_q} <= {scratch_adj[38:0], shift_q, 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
                // Results only move on the final shift, so an aborted run never leaks out.
                if (bit_cnt == 5'd31) begin
                    bcd      <= scratch_nxt[31:0];
                    overflow <= |scratch_nxt[39:32];
                end
            end
        end
    end

    always_comb begin
        nibble = bcd[{digit_idx, 2'b00} +: 4];
        upper  = bcd >> {digit_idx, 2'b00};
        if (overflow) begin
            seg_nxt = 7'h3F;
        end else if ((digit_idx != 3'd0) && (upper == 32'd0)) begin
            seg_nxt = 7'h7F;
        end else begin
            case (nibble)
                4'd0:    seg_nxt = 7'h40;
                4'd1:    seg_nxt = 7'h79;
                4'd2:    seg_nxt = 7'h24;
                4'd3:    seg_nxt = 7'h30;
                4'd4:    seg_nxt = 7'h19;
                4'd5:    seg_nxt = 7'h12;
                4'd6:    seg_nxt = 7'h02;
                4'd7:    seg_nxt = 7'h78;
                4'd8:    seg_nxt = 7'h00;
                4'd9:    seg_nxt = 7'h10;
                default: seg_nxt = 7'h7F;
            endcase
        end
    end

    // Scan runs regardless of the converter; outputs trail digit_idx by one edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            refresh_cnt <= 16'd0;
            digit_idx   <= 3'd0;
            digit_sel   <= 8'hFE;
            segments    <= 7'h40;
        end else begin
            if (refresh_cnt == 16'(REFRESH_DIV - 1)) begin
                refresh_cnt <= 16'd0;
                digit_idx   <= digit_idx + 3'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
            digit_sel <= ~(8'd1 << digit_idx);
            segments  <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display: decimal-arithmetic model of the BCD result,
// cycle-count model of the display scan, expected-queue scoreboard.
module tb_result_display;

    localparam int DIV = 4;

    logic        clk   = 1'b0;
    logic        clear = 1'b1;
    logic        load  = 1'b0;
    logic [31:0] value = 32'd0;
    logic        busy, ready, overflow;
    logic [31:0] bcd;
    logic [7:0]  digit_sel;
    logic [6:0]  segments;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int edges   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_bcd = 32'd0;
    logic        cur_ov  = 1'b0;

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .clear(clear), .load(load), .value(value),
        .busy(busy), .ready(ready), .overflow(overflow), .bcd(bcd),
        .digit_sel(digit_sel), .segments(segments), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Clock edges seen since clear was released.
    always @(posedge clk) begin
        if (clear) edges = 0;
        else       edges = edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_bcd(input logic [31:0] v);
        logic [63:0] x;
        logic [31:0] r;
        x = {32'd0, v};
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        int higher;
        if (cur_ov) return 7'h3F;
        higher = 0;
        for (int j = idx; j < 8; j++) higher += int'(cur_bcd[4*j +: 4]);
        if (idx > 0 && higher == 0) return 7'h7F;
        return digit_pattern(int'(cur_bcd[4*idx +: 4]));
    endfunction

    task automatic scan_check(input int n);
        int idx;
        logic [7:0] exp_sel;
        repeat (n) begin
            @(negedge clk);
            idx = (edges == 0) ? 0 : ((edges - 1) / DIV) % 8;
            exp_sel = ~(8'd1 << idx);
            check("digit_sel", {24'd0, digit_sel}, {24'd0, exp_sel});
            check("segments", {25'd0, segments}, {25'd0, exp_seg(idx)});
        end
    endtask

    // Loads v; if intr_k > 0 a second load of intr_v is pulsed at cycle intr_k of CONVERT.
    task automatic conv(input logic [31:0] v, input int intr_k, input logic [31:0] intr_v);
        int k, nbusy;
        logic [31:0] exp_b;
        logic exp_o;
        exp_q.push_back(model_bcd(v));
        exp_o = (v > 32'd99_999_999);
        @(negedge clk);
        load = 1'b1; value = v;
        @(negedge clk);
        load = 1'b0; value = $urandom;
        k = 0; nbusy = 0;
        do begin
            @(negedge clk);
            k++;
            load = (k == intr_k);
            if (k == intr_k) value = intr_v;
            if (busy) nbusy++;
            if (k == 16) check("bcd_hold", bcd, cur_bcd);
        end while (!ready && k < 100);
        load = 1'b0;
        if (k >= 100) check("ready_timeout", 32'd0, 32'd1);
        check("latency", k, 33);
        check("busy_cycles", nbusy, 32);
        exp_b = exp_q.pop_front();
        check("bcd", bcd, exp_b);
        check("overflow", {31'd0, overflow}, {31'd0, exp_o});
        check("busy_done", {31'd0, busy}, 32'd0);
        cur_bcd = exp_b;
        cur_ov  = exp_o;
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_bcd", bcd, 32'd0);
        check("rst_digit_sel", {24'd0, digit_sel}, 32'hFE);
        check("rst_segments", {25'd0, segments}, 32'h40);
        clear = 1'b0;
        scan_check(40);
        check("idle_ready", {31'd0, ready}, 32'd0);

        conv(32'd1234, 0, 32'd0);        scan_check(36);
        conv(32'd0, 0, 32'd0);           scan_check(36);
        conv(32'd99_999_999, 0, 32'd0);  scan_check(36);
        conv(32'd100_000_000, 0, 32'd0); scan_check(36);
        conv(32'd5, 10, 32'd77);
        conv(32'd77, 0, 32'd0);          scan_check(36);
        for (int i = 0; i < 6; i++) begin
            v = (i % 2 == 1) ? $urandom : $urandom_range(0, 99_999_999);
            conv(v, 0, 32'd0);
            scan_check(12);
        end

        // Abort a conversion half way through.
        @(negedge clk);
        load = 1'b1; value = 32'hFFFF_FFFF;
        @(negedge clk);
        load = 1'b0;
        repeat (16) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_bcd", bcd, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        check("abort_digit_sel", {24'd0, digit_sel}, 32'hFE);
        check("abort_segments", {25'd0, segments}, 32'h40);
        cur_bcd = 32'd0;
        cur_ov  = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        scan_check(40);
        check("post_clear_ready", {31'd0, ready}, 32'd0);
        check("post_clear_busy", {31'd0, busy}, 32'd0);
        check("post_clear_bcd", bcd, 32'd0);
        check("post_clear_overflow", {31'd0, overflow}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 1000, meaning clk cycles per display digit slot (legal range 2..65535).
REQ-002 The block SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 The block SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port load  input  1  one-cycle strobe: capture value and start conversion.
REQ-005 The block SHALL have port value  input  32  unsigned binary result to display.
REQ-006 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 The block SHALL have port ready  output  1  high once a conversion has completed and bcd is valid.
REQ-008 The block SHALL have port overflow  output  1  high when the last converted value exceeds 99_999_999.
REQ-009 The block SHALL have port bcd  output  32  eight BCD digits of the last result; digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port digit_sel  output  8  one-hot active-low anode select; bit i drives digit i.
REQ-011 The block SHALL have port segments  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 The block SHALL implement FSM states IDLE, CONVERT and DONE.
REQ-013 In IDLE or DONE, load=1 SHALL capture value into a 32-bit shift register, clear a 40-bit BCD scratch register, and enter CONVERT next cycle.
REQ-014 load during CONVERT SHALL be ignored; the conversion in progress SHALL be unaffected.
REQ-015 CONVERT SHALL run sequential double-dabble for exactly 32 cycles, one bit per cycle: each of the 10 scratch nibbles >=5 gets +3, then {scratch,shift} shifts left by 1.
REQ-016 On the 32nd CONVERT cycle the FSM SHALL enter DONE.
REQ-017 On entering DONE, bcd SHALL take scratch[31:0] and overflow SHALL take (scratch[39:32] != 0).
REQ-018 bcd and overflow SHALL hold their previous values throughout CONVERT.
REQ-019 busy SHALL be 1 exactly in CONVERT.
REQ-020 ready SHALL be 1 exactly in DONE.
REQ-021 Latency from load to ready SHALL be 33 cycles: load sampled at edge N, ready=1 after edge N+33.
REQ-022 A refresh counter SHALL count 0..REFRESH_DIV-1 continuously; on wrap, the active digit index SHALL advance 0->1->...->7->0.
REQ-023 Refresh scanning SHALL be independent of FSM state.
REQ-024 digit_sel SHALL drive low only the bit of the active digit index.
REQ-025 segments SHALL show the standard 0-9 pattern for the active digit's BCD nibble.
REQ-026 Leading-zero blanking: digit i (i>=1) SHALL be blank (segments=7'h7F) when bcd digits i..7 are all zero; digit 0 SHALL never be blanked.
REQ-027 When overflow=1, every digit SHALL show a dash (segments=7'h3F).
REQ-028 A nibble value 10..15 SHALL display blank (7'h7F).
REQ-029 Outputs digit_sel and segments SHALL be registered, one cycle behind the digit index change.

Reset
REQ-030 clear=1 SHALL immediately, and asynchronously, force: FSM=IDLE, busy=0, ready=0, overflow=0, bcd=0, refresh counter=0, digit index=0, digit_sel=8'hFE, segments=7'h40 (digit "0").
REQ-031 clear asserted mid-CONVERT SHALL abort the conversion; no partial result SHALL reach bcd.
REQ-032 After clear deasserts, the block SHALL remain in IDLE until a load.
REQ-033 Scanning SHALL resume from digit 0 on the first edge after clear deasserts.

Verification
REQ-034 Load value=1234 -> busy for 32 cycles; then ready=1 at cycle 33, bcd=32'h0000_1234, overflow=0; scan shows "1234" on digits 3..0, with digits 7..4 blank.
REQ-035 Load value=0 -> bcd=0; digit 0 shows "0" (7'h40); digits 1..7 show 7'h7F.
REQ-036 Load value=99_999_999 -> bcd=32'h9999_9999, overflow=0; load value=100_000_000 -> overflow=1, all digits 7'h3F.
REQ-037 Load value=5 -> then, 10 cycles later, load value=77 -> second load ignored, bcd=32'h5; a subsequent load of 77 in DONE -> bcd=32'h77.
REQ-038 Assert clear at CONVERT cycle 16 of value=4_294_967_295 -> bcd=0, ready=0, busy=0 immediately; no overflow is flagged.
REQ-039 REFRESH_DIV=4 -> digit_sel steps FE,FD,FB,...,7F,FE every 4 cycles with no skipped or duplicated slot at the 7->0 wrap.
